// File: rtl/nco_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// nco_pkg : scheduler state type, default sizes, phase-to-address map
// Rev 1.0
// ------------------------------------------------------------------
package nco_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int NCH_DEF     = 4;
  localparam int PHASE_W_DEF = 16;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int ROM_LAT_DEF = 1;

  // Top addr_w bits of a phase_w-bit phase; caller truncates to its address width.
  function automatic logic [31:0] phase2addr(input logic [31:0] phase,
                                             input int          phase_w,
                                             input int          addr_w);
    return phase >> (phase_w - addr_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nco_slot_sched_if.sv
`default_nettype none
// ------------------------------------------------------------------
// nco_slot_sched_if : config, shared-ROM and sample-stream bundle
// Rev 1.0
// ------------------------------------------------------------------
interface nco_slot_sched_if #(
  parameter int NCH     = nco_pkg::NCH_DEF,
  parameter int PHASE_W = nco_pkg::PHASE_W_DEF,
  parameter int ADDR_W  = nco_pkg::ADDR_W_DEF,
  parameter int DATA_W  = nco_pkg::DATA_W_DEF
);
  localparam int CH_W = $clog2(NCH);

  logic               tick;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [PHASE_W-1:0] cfg_inc;
  logic               cfg_en;
  logic               ovr_clr;
  logic               rom_req;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;
  logic               out_valid;
  logic [CH_W-1:0]    out_ch;
  logic [DATA_W-1:0]  out_sample;
  logic               busy;
  logic               overrun;

  modport master (
    output tick, cfg_valid, cfg_ch, cfg_inc, cfg_en, ovr_clr, rom_data,
    input  cfg_ready, rom_req, rom_addr, out_valid, out_ch, out_sample, busy, overrun
  );

  modport slave (
    input  tick, cfg_valid, cfg_ch, cfg_inc, cfg_en, ovr_clr, rom_data,
    output cfg_ready, rom_req, rom_addr, out_valid, out_ch, out_sample, busy, overrun
  );

endinterface
`default_nettype wire

// File: rtl/nco_phase_bank.sv
`default_nettype none
// ------------------------------------------------------------------
// nco_phase_bank : per-channel phase/increment/enable register file
// Rev 1.0
// ------------------------------------------------------------------
module nco_phase_bank #(
  parameter  int NCH     = nco_pkg::NCH_DEF,
  parameter  int PHASE_W = nco_pkg::PHASE_W_DEF,
  localparam int CH_W    = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [PHASE_W-1:0] wr_inc,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    rd_slot,
  output logic [PHASE_W-1:0] rd_phase,
  output logic               rd_en,
  input  logic               acc
);

  logic [PHASE_W-1:0] w_phase [NCH];
  logic [NCH-1:0]     w_en;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [PHASE_W-1:0] r_phase;
      logic [PHASE_W-1:0] r_inc;
      logic               r_en;
      logic               w_sel_wr;
      logic               w_sel_acc;

      assign w_sel_wr  = wr_valid && (wr_ch == CH_W'(i));
      assign w_sel_acc = acc && (rd_slot == CH_W'(i));

      // Writes only happen in IDLE and accumulates only in RUN, so they never collide.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_phase <= '0;
          r_inc   <= '0;
          r_en    <= 1'b0;
        end else if (w_sel_wr) begin
          r_inc <= wr_inc;
          r_en  <= wr_en;
          if (!wr_en) r_phase <= '0;
        end else if (w_sel_acc) begin
          r_phase <= r_phase + r_inc;
        end
      end

      assign w_phase[i] = r_phase;
      assign w_en[i]    = r_en;
    end
  endgenerate

  assign rd_phase = w_phase[rd_slot];
  assign rd_en    = w_en[rd_slot];

endmodule
`default_nettype wire

// File: rtl/nco_slot_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// nco_slot_sched : round-robin NCO scheduler sharing one sine ROM
// Rev 1.0
// ------------------------------------------------------------------
module nco_slot_sched
  import nco_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  nco_slot_sched_if.slave   bus
);

  localparam int CH_W = $clog2(NCH);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  logic [CH_W-1:0]    r_slot;
  logic [1:0]         r_drain_cnt;
  logic               w_idle;
  logic               w_run;
  logic               w_drain;
  logic               w_last_slot;
  logic               w_drain_done;
  logic               w_cfg_fire;
  logic               w_issue;
  logic [PHASE_W-1:0] w_rd_phase;
  logic               w_rd_en;
  logic               r_overrun;
  logic               r_pipe_vld [ROM_LAT];
  logic [CH_W-1:0]    r_pipe_ch  [ROM_LAT];

  assign w_last_slot  = (r_slot == CH_W'(NCH - 1));
  assign w_drain_done = (r_drain_cnt == 2'(ROM_LAT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.tick)     w_state_nxt = RUN;
      RUN:     if (w_last_slot)  w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_done) w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_idle  = 1'b0;
    w_run   = 1'b0;
    w_drain = 1'b0;
    case (r_state)
      IDLE:    w_idle  = 1'b1;
      RUN:     w_run   = 1'b1;
      DRAIN:   w_drain = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot      <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_run) r_slot <= w_last_slot ? '0 : r_slot + 1'b1;
      if (w_drain && !w_drain_done) r_drain_cnt <= r_drain_cnt + 2'd1;
      else                          r_drain_cnt <= '0;
    end
  end

  assign w_cfg_fire = bus.cfg_valid && w_idle;
  assign w_issue    = w_run && w_rd_en;

  nco_phase_bank #(
    .NCH     (NCH),
    .PHASE_W (PHASE_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (w_cfg_fire),
    .wr_ch    (bus.cfg_ch),
    .wr_inc   (bus.cfg_inc),
    .wr_en    (bus.cfg_en),
    .rd_slot  (r_slot),
    .rd_phase (w_rd_phase),
    .rd_en    (w_rd_en),
    .acc      (w_issue)
  );

  // Tag pipe matches the ROM latency so each returned word carries its channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_ch[i]  <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_ch[0]  <= r_slot;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_ch[i]  <= r_pipe_ch[i-1];
      end
    end
  end

  // A dropped tick outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_overrun <= 1'b0;
    else if (bus.tick && !w_idle) r_overrun <= 1'b1;
    else if (bus.ovr_clr)         r_overrun <= 1'b0;
  end

  assign bus.rom_req    = w_issue;
  assign bus.rom_addr   = w_issue ? ADDR_W'(phase2addr(32'(w_rd_phase), PHASE_W, ADDR_W)) : '0;
  assign bus.out_valid  = r_pipe_vld[ROM_LAT-1];
  assign bus.out_ch     = r_pipe_vld[ROM_LAT-1] ? r_pipe_ch[ROM_LAT-1] : '0;
  assign bus.out_sample = r_pipe_vld[ROM_LAT-1] ? bus.rom_data : '0;
  assign bus.busy       = !w_idle;
  assign bus.cfg_ready  = w_idle;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nco_slot_sched.sv
`default_nettype none
// tb_nco_slot_sched : scenario tasks with a tagged-sample scoreboard
// and a behavioural phase model for the NCO slot scheduler.
module tb_nco_slot_sched;

  localparam int NCH     = 4;
  localparam int PHASE_W = 16;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int ROM_LAT = 1;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] sample;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_out = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] m_phase [NCH];
  logic [15:0] m_inc   [NCH];
  logic        m_en    [NCH];
  logic [7:0]  last_addr [NCH];
  logic [15:0] rom_q = 16'h0;

  nco_slot_sched_if #(.NCH(NCH), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  nco_slot_sched #(
    .NCH(NCH), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Address-unique ROM contents, one cycle of read latency.
  function automatic logic [15:0] rom_val(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  always @(posedge clk) rom_q <= bus.rom_req ? rom_val(bus.rom_addr) : 16'h0;
  assign bus.rom_data = rom_q;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      n_out++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: out_ch=%0d out_sample=%h with nothing expected", bus.out_ch, bus.out_sample);
      end else begin
        mon_e = sb.pop_front();
        if (bus.out_ch !== mon_e.ch || bus.out_sample !== mon_e.sample || cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL sb_sample: got ch=%0d sample=%h cyc=%0d, expected ch=%0d sample=%h cyc=%0d",
                   bus.out_ch, bus.out_sample, cyc, mon_e.ch, mon_e.sample, mon_e.cyc);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_phase[i] = 16'h0;
      m_inc[i]   = 16'h0;
      m_en[i]    = 1'b0;
    end
    sb.delete();
  endtask

  task automatic do_cfg(input int ch, input logic [15:0] inc, input logic en);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_inc   = inc;
    bus.cfg_en    = en;
    while (bus.cfg_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (bus.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_timeout: cfg_ready=%b after %0d cycles, expected 1", bus.cfg_ready, waited);
    end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    m_inc[ch] = inc;
    m_en[ch]  = en;
    if (!en) m_phase[ch] = 16'h0;
  endtask

  // Called at the negedge of the cycle that issues slot k.
  task automatic issue_slot(input int k);
    logic [7:0] ea;
    ea = m_phase[k][15:8];
    last_addr[k] = bus.rom_addr;
    n_checks++;
    if (bus.rom_req !== m_en[k]) begin
      n_fail++;
      $display("FAIL slot%0d_req: rom_req=%b expected %b", k, bus.rom_req, m_en[k]);
    end
    if (m_en[k]) begin
      n_checks++;
      if (bus.rom_addr !== ea) begin
        n_fail++;
        $display("FAIL slot%0d_addr: rom_addr=%h expected %h", k, bus.rom_addr, ea);
      end
      sb.push_back('{ch: 2'(k), sample: rom_val(ea), cyc: cyc + ROM_LAT});
      m_phase[k] = m_phase[k] + m_inc[k];
    end
  endtask

  task automatic run_frame(input int xtick, input bit cfg_run, input int cch,
                           input logic [15:0] cinc, output int ns);
    int n0, busy_cnt, rdy_bad;
    n0 = n_out; busy_cnt = 0; rdy_bad = 0;
    @(negedge clk);
    bus.tick = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      bus.tick = (k == xtick);
      if (cfg_run && k == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 2'(cch);
        bus.cfg_inc   = cinc;
        bus.cfg_en    = 1'b1;
      end
      busy_cnt += int'(bus.busy);
      rdy_bad  += int'(bus.cfg_ready);
      issue_slot(k);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.tick = 1'b0;
      if (bus.busy !== 1'b1) break;
      busy_cnt++;
      rdy_bad += int'(bus.cfg_ready);
    end
    n_checks++;
    if (busy_cnt != NCH + ROM_LAT) begin
      n_fail++;
      $display("FAIL busy_len: busy high %0d cycles, expected %0d", busy_cnt, NCH + ROM_LAT);
    end
    n_checks++;
    if (rdy_bad != 0 || bus.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_ready_frame: ready during frame %0d cycles, ready after=%b, expected 0 and 1",
               rdy_bad, bus.cfg_ready);
    end
    if (cfg_run) begin
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      m_inc[cch] = cinc;
      m_en[cch]  = 1'b1;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d samples missing, expected 0", sb.size());
    end
    ns = n_out - n0;
  endtask

  task automatic test_reset();
    int ns;
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    n_checks++;
    if ({bus.rom_req, bus.rom_addr, bus.out_valid, bus.out_ch, bus.out_sample, bus.busy, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b addr=%h vld=%b ch=%0d smp=%h busy=%b ovr=%b, expected all 0",
               bus.rom_req, bus.rom_addr, bus.out_valid, bus.out_ch, bus.out_sample, bus.busy, bus.overrun);
    end
    n_checks++;
    if (bus.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cfg_ready: cfg_ready=%b expected 1", bus.cfg_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.rom_req, bus.out_valid, bus.busy, bus.overrun} !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: req=%b vld=%b busy=%b ovr=%b, expected 0",
               bus.rom_req, bus.out_valid, bus.busy, bus.overrun);
    end
    run_frame(-1, 1'b0, 0, 16'h0, ns);
    n_checks++;
    if (ns != 0) begin
      n_fail++;
      $display("FAIL empty_frame: %0d samples, expected 0", ns);
    end
  endtask

  task automatic test_single();
    int ns;
    do_cfg(0, 16'h0100, 1'b1);
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, 1'b0, 0, 16'h0, ns);
      @(negedge clk);
      n_checks++;
      if (ns != 1 || last_addr[0] !== 8'(f)) begin
        n_fail++;
        $display("FAIL single_f%0d: samples=%0d addr=%h, expected 1 and %h", f, ns, last_addr[0], 8'(f));
      end
    end
  endtask

  task automatic test_all();
    int ns;
    logic [7:0] exp_a [NCH];
    logic [15:0] incs [NCH];
    exp_a = '{8'h02, 8'h04, 8'h80, 8'h00};
    incs  = '{16'h0100, 16'h0200, 16'h4000, 16'h8000};
    for (int c = 0; c < NCH; c++) do_cfg(c, 16'h0, 1'b0);
    for (int c = 0; c < NCH; c++) do_cfg(c, incs[c], 1'b1);
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, 1'b0, 0, 16'h0, ns);
      n_checks++;
      if (ns != 4) begin
        n_fail++;
        $display("FAIL all_count_f%0d: %0d samples, expected 4", f, ns);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      n_checks++;
      if (last_addr[c] !== exp_a[c]) begin
        n_fail++;
        $display("FAIL all_addr_ch%0d: rom_addr=%h expected %h", c, last_addr[c], exp_a[c]);
      end
    end
  endtask

  task automatic test_wrap();
    int ns;
    logic [7:0] exp_a [4];
    exp_a = '{8'h00, 8'hFF, 8'hFE, 8'hFD};
    for (int c = 0; c < NCH; c++) do_cfg(c, 16'h0, 1'b0);
    do_cfg(0, 16'hFF00, 1'b1);
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, 1'b0, 0, 16'h0, ns);
      n_checks++;
      if (ns != 1 || last_addr[0] !== exp_a[f]) begin
        n_fail++;
        $display("FAIL wrap_f%0d: samples=%0d addr=%h, expected 1 and %h", f, ns, last_addr[0], exp_a[f]);
      end
    end
  endtask

  task automatic test_overrun();
    int ns;
    do_cfg(1, 16'h0100, 1'b1);
    do_cfg(2, 16'h0200, 1'b1);
    do_cfg(3, 16'h0300, 1'b1);
    run_frame(1, 1'b1, 1, 16'h0700, ns);
    n_checks++;
    if (ns != 4 || bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: samples=%0d overrun=%b, expected 4 and 1", ns, bus.overrun);
    end
    @(negedge clk); bus.ovr_clr = 1'b1;
    @(negedge clk); bus.ovr_clr = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clr: overrun=%b expected 0", bus.overrun);
    end
    run_frame(-1, 1'b0, 0, 16'h0, ns);
    n_checks++;
    if (ns != 4) begin
      n_fail++;
      $display("FAIL after_overrun: %0d samples, expected 4", ns);
    end
  endtask

  task automatic test_disable_abort();
    int ns, bad;
    do_cfg(1, 16'h0700, 1'b0);
    run_frame(-1, 1'b0, 0, 16'h0, ns);
    n_checks++;
    if (ns != 3) begin
      n_fail++;
      $display("FAIL disable_count: %0d samples, expected 3", ns);
    end
    do_cfg(1, 16'h0700, 1'b1);
    run_frame(-1, 1'b0, 0, 16'h0, ns);
    n_checks++;
    if (ns != 4 || last_addr[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL reenable: samples=%0d ch1 addr=%h, expected 4 and 00", ns, last_addr[1]);
    end
    @(negedge clk); bus.tick = 1'b1;
    @(negedge clk); bus.tick = 1'b0; issue_slot(0);
    @(negedge clk); issue_slot(1);
    @(negedge clk);
    n_checks++;
    if (bus.rom_req !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: rom_req=%b busy=%b in slot 2, expected 1 and 1", bus.rom_req, bus.busy);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.rom_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_now: vld=%b busy=%b req=%b, expected 000", bus.out_valid, bus.busy, bus.rom_req);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      bad += int'(bus.out_valid | bus.busy | bus.rom_req);
    end
    n_checks++;
    if (bad != 0 || bus.cfg_ready !== 1'b1 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: active cycles=%0d cfg_ready=%b overrun=%b, expected 0, 1, 0",
               bad, bus.cfg_ready, bus.overrun);
    end
    do_cfg(2, 16'h1000, 1'b1);
    run_frame(-1, 1'b0, 0, 16'h0, ns);
    n_checks++;
    if (ns != 1 || last_addr[2] !== 8'h00) begin
      n_fail++;
      $display("FAIL post_abort: samples=%0d ch2 addr=%h, expected 1 and 00", ns, last_addr[2]);
    end
  endtask

  initial begin
    bus.tick      = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_inc   = '0;
    bus.cfg_en    = 1'b0;
    bus.ovr_clr   = 1'b0;
    test_reset();
    test_single();
    test_all();
    test_wrap();
    test_overrun();
    test_disable_abort();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
